// File: rtl/button_pkg.sv
// Shared button front-end types and default timing constants.
// Default counts are also used by the blinker timer.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 1000;
    localparam int DEF_REPEAT_DELAY    = 50000000;
    localparam int DEF_REPEAT_PERIOD   = 12500000;

endpackage

// File: rtl/debounce_channel.sv
// One button: 2-FF sync, debounce FSM, registered press pulse.
// Auto-repeat while held is built only with AUTO_REPEAT_EN defined.
module debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

    logic          s1, s2;
    btn_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic          accept;
    logic          rep_hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            press <= accept | rep_hit;
        end
    end

    // cnt holds stable samples already seen; the current one completes the run
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        unique case (state)
            IDLE: begin
                if (s2) begin
                    if (SINGLE) begin
                        state_n = HELD;
                        accept  = 1'b1;
                    end else begin
                        state_n = PRESS_WAIT;
                        cnt_n   = CW'(1);
                    end
                end
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = HELD;
                    cnt_n   = '0;
                    accept  = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            HELD: begin
                if (!s2) begin
                    if (SINGLE) begin
                        state_n = IDLE;
                    end else begin
                        state_n = RELEASE_WAIT;
                        cnt_n   = CW'(1);
                    end
                end
            end
            RELEASE_WAIT: begin
                if (s2) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        level = (state == HELD) || (state == RELEASE_WAIT);
    end

`ifdef AUTO_REPEAT_EN
    localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW = $clog2(HMAX + 1);

    logic [HW-1:0] hc, hc_inc, hc_target;
    logic          rep;
    logic          holding;

    assign holding   = (state == HELD) && (state_n == HELD);
    assign hc_inc    = hc + 1'b1;
    assign hc_target = rep ? HW'(REPEAT_PERIOD) : HW'(REPEAT_DELAY);
    assign rep_hit   = holding && (hc_inc == hc_target);

    always_ff @(posedge clk) begin
        if (!rst || !holding) begin
            hc  <= '0;
            rep <= 1'b0;
        end else if (rep_hit) begin
            hc  <= '0;
            rep <= 1'b1;
        end else begin
            hc <= hc_inc;
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign rep_hit = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Two debounced buttons -> registered shift requests and levels.
// Define AUTO_REPEAT_EN to enable auto-repeat while a button is held.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_left_raw,
    input  logic btn_right_raw,
    output logic shift_left,
    output logic shift_right,
    output logic left_level,
    output logic right_level
);

    logic l_level, l_press;
    logic r_level, r_press;

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_left (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_left_raw),
        .level(l_level),
        .press(l_press)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_right (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_right_raw),
        .level(r_level),
        .press(r_press)
    );

    // simultaneous presses are ambiguous, so drop both
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_left  <= 1'b0;
            shift_right <= 1'b0;
            left_level  <= 1'b0;
            right_level <= 1'b0;
        end else begin
            shift_left  <= l_press & ~r_press;
            shift_right <= r_press & ~l_press;
            left_level  <= l_level;
            right_level <= r_level;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a pulse scoreboard.
// Define AUTO_REPEAT_EN to also exercise the hold auto-repeat.
module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic btn_left_raw, btn_right_raw;
    logic shift_left, shift_right;
    logic left_level, right_level;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int base = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int   at_edge;
        logic left;
    } pulse_t;

    pulse_t exp_q[$];
    logic exp_l, exp_r;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_left_raw (btn_left_raw),
        .btn_right_raw(btn_right_raw),
        .shift_left   (shift_left),
        .shift_right  (shift_right),
        .left_level   (left_level),
        .right_level  (right_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic go(input int n);
        while (cyc < base + n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic push(input int rel, input logic left);
        pulse_t p;
        p.at_edge = base + rel;
        p.left    = left;
        exp_q.push_back(p);
    endtask

    // per-cycle pulse scoreboard; an empty slot means both must be 0
    always @(negedge clk) begin
        if (mon_en) begin
            exp_l = 1'b0;
            exp_r = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].at_edge == cyc) begin
                exp_l = exp_q[0].left;
                exp_r = !exp_q[0].left;
                void'(exp_q.pop_front());
            end
            checks++;
            assert ({shift_left, shift_right} === {exp_l, exp_r})
            else begin
                errors++;
                $error("FAIL pulse cyc=%0d got=%b%b exp=%b%b",
                       cyc, shift_left, shift_right, exp_l, exp_r);
            end
        end
    end

    initial begin
        rst = 1'b0;
        btn_left_raw = 1'b0;
        btn_right_raw = 1'b0;
        base = 0;
        go(3);
        chk("rst_sl", shift_left, 1'b0);
        chk("rst_sr", shift_right, 1'b0);
        chk("rst_ll", left_level, 1'b0);
        chk("rst_rl", right_level, 1'b0);
        rst = 1'b1;
        mon_en = 1'b1;
        go(8);

        // single press, held, released
        base = cyc;
        go(9);
        btn_left_raw = 1'b1;
        push(16, 1'b1);
        go(15);
        chk("t1_ll_pre", left_level, 1'b0);
        go(16);
        chk("t1_ll_acc", left_level, 1'b1);
        go(25);
        btn_left_raw = 1'b0;
        go(31);
        chk("t5_ll_hold", left_level, 1'b1);
        go(32);
        chk("t5_ll_drop", left_level, 1'b0);
        go(45);

        // 3-cycle bounce is rejected
        base = cyc;
        go(9);
        btn_left_raw = 1'b1;
        go(12);
        btn_left_raw = 1'b0;
        go(16);
        chk("t2_ll_16", left_level, 1'b0);
        go(22);
        chk("t2_ll_22", left_level, 1'b0);
        go(30);

        // exactly 4 stable cycles is accepted
        base = cyc;
        go(9);
        btn_left_raw = 1'b1;
        go(13);
        btn_left_raw = 1'b0;
        push(16, 1'b1);
        go(16);
        chk("t2b_ll_acc", left_level, 1'b1);
        go(19);
        chk("t2b_ll_hold", left_level, 1'b1);
        go(20);
        chk("t2b_ll_drop", left_level, 1'b0);
        go(30);

        // simultaneous press: no pulses, levels still track
        base = cyc;
        go(9);
        btn_left_raw = 1'b1;
        btn_right_raw = 1'b1;
        go(16);
        chk("t3_ll", left_level, 1'b1);
        chk("t3_rl", right_level, 1'b1);
        go(25);
        btn_left_raw = 1'b0;
        btn_right_raw = 1'b0;
        go(40);

        // one cycle apart: both pass
        base = cyc;
        go(9);
        btn_left_raw = 1'b1;
        push(16, 1'b1);
        go(10);
        btn_right_raw = 1'b1;
        push(17, 1'b0);
        go(17);
        chk("t3b_rl", right_level, 1'b1);
        go(25);
        btn_left_raw = 1'b0;
        btn_right_raw = 1'b0;
        go(40);

        // reset mid-debounce, then mid-hold
        base = cyc;
        go(9);
        btn_left_raw = 1'b1;
        go(13);
        rst = 1'b0;
        go(14);
        chk("t4_sl", shift_left, 1'b0);
        chk("t4_ll", left_level, 1'b0);
        rst = 1'b1;
        push(21, 1'b1);
        go(20);
        chk("t4_ll_pre", left_level, 1'b0);
        go(21);
        chk("t4_ll_acc", left_level, 1'b1);
        go(25);
        rst = 1'b0;
        go(26);
        chk("t4_ll_rst", left_level, 1'b0);
        rst = 1'b1;
        push(33, 1'b1);
        go(33);
        chk("t4_ll_acc2", left_level, 1'b1);
        go(40);
        btn_left_raw = 1'b0;
        go(55);

`ifdef AUTO_REPEAT_EN
        // long hold: acceptance then +20, +28, ...
        base = cyc;
        go(9);
        btn_left_raw = 1'b1;
        push(16, 1'b1);
        push(36, 1'b1);
        push(44, 1'b1);
        push(52, 1'b1);
        push(60, 1'b1);
        push(68, 1'b1);
        go(69);
        btn_left_raw = 1'b0;
        go(90);
        chk("t6_ll_end", left_level, 1'b0);
`endif

        mon_en = 1'b0;
        checks++;
        assert (exp_q.size() == 0)
        else begin
            errors++;
            $error("FAIL q_empty got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
